hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised successor to the pipeline hazard controller: a register scoreboard that tracks in-flight destination registers of variable-latency operations (multi-cycle MDU, LSU loads waiting on memory) and resolves RAW, WAW and structural hazards for the ID stage. It sits beside the ID stage, receives issue, cancel and writeback events, and produces the ID stall, per-source writeback bypass selects and occupancy/performance state. Single-cycle ALU results continue to use the existing EX/MEM/WB forwarding network; this block covers only operations flagged long-latency.

## Interface
- NUM_RS, 2: source operands checked per ID instruction (1..3).
- NUM_WB, 2: writeback ports that retire long-latency results (1..4).
- MAX_OUTSTANDING, 4: maximum simultaneously pending registers (1..31).
- STALL_CNT_W, 16: stall performance counter width.

- clk_i  in  1  clock, all state on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- id_valid_i  in  1  valid instruction in ID.
- id_rs_addr_i  in  NUM_RS*5  source addresses, operand i at [5i+4:5i].
- id_rs_used_i  in  NUM_RS  operand i is read.
- id_rd_addr_i  in  5  destination address.
- id_rd_we_i  in  1  instruction writes rd.
- id_long_i  in  1  instruction goes to a long-latency unit.
- flush_id_i  in  1  ID instruction is being flushed.
- cancel_valid_i  in  1  an issued long op is killed downstream.
- cancel_addr_i  in  5  rd of the killed op.
- wb_valid_i  in  NUM_WB  writeback port k retires a result this cycle.
- wb_addr_i  in  NUM_WB*5  port k rd at [5k+4:5k].
- stall_clr_i  in  1  synchronous clear of stall counter.
- stall_id_o  out  1  hold IF/ID, bubble into EX.
- fwd_wb_sel_o  out  NUM_RS*NUM_WB  one-hot per operand: bypass from port k.
- pending_o  out  32  scoreboard bits; bit 0 constant 0.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  number of pending bits set.
- stall_cnt_o  out  STALL_CNT_W  cycles with stall_id_o high, saturating.

## Operation
- clear[r] = (any wb_valid_i[k] with wb_addr k == r) or (cancel_valid_i and cancel_addr_i == r).
- RAW on operand i: id_valid_i, id_rs_used_i[i], addr != 0, pending[addr], and no wb port writes addr this cycle.
- Bypass: operand i used, addr != 0, pending[addr], wb port k writes addr -> fwd_wb_sel bit (i,k) set; lowest k wins if several match (several matching ports is illegal, flag in bench). Otherwise all zero.
- WAW: id_valid_i, id_rd_we_i, rd != 0, pending[rd], not clear[rd] this cycle.
- Structural: id_valid_i, id_long_i, id_rd_we_i, rd != 0, outstanding_o == MAX_OUTSTANDING, and no pending bit cleared this cycle.
- stall_id_o = RAW(any i) or WAW or structural; forced 0 when flush_id_i.
- issue = id_valid_i, id_long_i, id_rd_we_i, rd != 0, !stall_id_o, !flush_id_i.
- Next pending[r] = (pending[r] and !clear[r]) or (issue and rd == r): set wins over clear on the same address.
- outstanding_o tracks popcount of pending at all times (update by +issue minus distinct bits actually cleared; clears of non-pending registers have no effect).
- Writes to x0 never set pending; x0 sources never stall or bypass.
- stall_cnt_o increments when stall_id_o is 1, saturates at all-ones; stall_clr_i has priority over increment.

## Timing
- Reset: pending_o = 0, outstanding_o = 0, stall_cnt_o = 0; stall_id_o and fwd_wb_sel_o are then 0 for any input with no pending bits.
- stall_id_o and fwd_wb_sel_o are combinational from registered pending and current inputs; no registered outputs on the stall path.
- Issue in cycle N -> pending bit and outstanding_o visible in N+1; dependent instruction in N+1 stalls.
- Writeback in cycle N -> dependent instruction in ID proceeds in N with bypass; bit clear from N+1.
- Cancel in cycle N -> bit clear from N+1; does not release a stall in N (cancel is not bypass data) except WAW and structural, which see the clear.
- Reset assertion mid-operation clears all state immediately, independent of clk_i.

## Test plan
- Reset then long load to x5 issued, next instruction reads x5: stall_id_o=1 each cycle until wb port 0 writes x5; in that cycle stall_id_o=0, fwd_wb_sel_o operand0 = 2'b01; pending_o[5]=0 afterwards.
- Pending x7, ID writes x7 (short op), no wb: stall_id_o=1 (WAW); wb port 1 retires x7 -> stall_id_o=0 same cycle.
- MAX_OUTSTANDING=4, issue long ops to x1..x4: outstanding_o=4; fifth long op to x6 stalls; wb of x2 that cycle releases it, outstanding_o stays 4.
- Same cycle wb x9 and new long issue to x9: pending_o[9]=1 next cycle, outstanding_o unchanged.
- Cancel x3 while pending, flush_id_i with RAW on x3: stall_id_o=0 under flush, pending_o[3]=0 next cycle; x0 sources/dest never stall.
- Hold a RAW stall 70000 cycles with STALL_CNT_W=16: stall_cnt_o saturates at 16'hFFFF; stall_clr_i -> 0 next cycle.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
//
// Register scoreboard for long-latency operations (multi-cycle MDU, LSU loads).
// Tracks which architectural registers have a result still in flight and
// resolves RAW, WAW and structural hazards for the instruction sitting in ID.
// Single-cycle ALU results are not tracked here; they use the normal
// EX/MEM/WB forwarding network.
//
// Ports
//   clk_i, rst_n_i     clock (rising edge) and asynchronous active-low reset
//   id_valid_i         valid instruction in ID
//   id_rs_addr_i       NUM_RS source addresses, operand i at [5i+4:5i]
//   id_rs_used_i       operand i is actually read
//   id_rd_addr_i       destination register
//   id_rd_we_i         instruction writes rd
//   id_long_i          instruction goes to a long-latency unit
//   flush_id_i         ID instruction is being flushed
//   cancel_valid_i     an issued long op was killed downstream
//   cancel_addr_i      rd of the killed op
//   wb_valid_i         NUM_WB writeback ports retiring long results
//   wb_addr_i          rd of writeback port k at [5k+4:5k]
//   stall_clr_i        synchronous clear of the stall counter
//   stall_id_o         hold IF/ID, bubble into EX
//   fwd_wb_sel_o       per operand one-hot bypass select, bit (i*NUM_WB + k)
//   pending_o          scoreboard bits (bit 0 always 0)
//   outstanding_o      number of pending bits set
//   stall_cnt_o        saturating count of stalled cycles
// ----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NUM_RS          = 2,
    parameter int NUM_WB          = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STALL_CNT_W     = 16,
    localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       id_valid_i,
    input  logic [NUM_RS*5-1:0]        id_rs_addr_i,
    input  logic [NUM_RS-1:0]          id_rs_used_i,
    input  logic [4:0]                 id_rd_addr_i,
    input  logic                       id_rd_we_i,
    input  logic                       id_long_i,
    input  logic                       flush_id_i,
    input  logic                       cancel_valid_i,
    input  logic [4:0]                 cancel_addr_i,
    input  logic [NUM_WB-1:0]          wb_valid_i,
    input  logic [NUM_WB*5-1:0]        wb_addr_i,
    input  logic                       stall_clr_i,
    output logic                       stall_id_o,
    output logic [NUM_RS*NUM_WB-1:0]   fwd_wb_sel_o,
    output logic [31:0]                pending_o,
    output logic [OUT_W-1:0]           outstanding_o,
    output logic [STALL_CNT_W-1:0]     stall_cnt_o
);

    logic [31:0]             pending_reg, pending_next;
    logic [OUT_W-1:0]        outstanding_reg, outstanding_next;
    logic [STALL_CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;

    logic [31:0]             wb_hit_vec;   // some wb port writes register r now
    logic [31:0]             clear_vec;    // wb or cancel targets register r
    logic [31:0]             clear_eff;    // clears that actually drop a pending bit
    logic [31:0]             set_vec;
    logic [NUM_RS-1:0]       raw_vec;
    logic [5:0]              cleared_cnt;
    logic [5:0]              outstanding_sum;
    logic                    rd_nz;
    logic                    waw;
    logic                    structural;
    logic                    stall;
    logic                    issue;

    genvar gi;

    // ------------------------------------------------------------------
    // Per-register clear decode
    // ------------------------------------------------------------------
    for (gi = 0; gi < 32; gi++) begin : g_clear
        logic hit;
        always_comb begin
            hit = 1'b0;
            for (int k = 0; k < NUM_WB; k++) begin
                if (wb_valid_i[k] && (wb_addr_i[5*k +: 5] == 5'(gi))) begin
                    hit = 1'b1;
                end
            end
        end
        assign wb_hit_vec[gi] = hit;
        assign clear_vec[gi]  = hit | (cancel_valid_i && (cancel_addr_i == 5'(gi)));
    end

    assign clear_eff = clear_vec & pending_reg;

    // ------------------------------------------------------------------
    // Per-operand RAW detection and writeback bypass select
    // ------------------------------------------------------------------
    for (gi = 0; gi < NUM_RS; gi++) begin : g_operand
        logic [4:0]        rs;
        logic              live;
        logic [NUM_WB-1:0] sel;

        assign rs   = id_rs_addr_i[5*gi +: 5];
        assign live = id_rs_used_i[gi] && (rs != 5'd0) && pending_reg[rs];

        // A cancel is not data, so only a real writeback releases the RAW.
        assign raw_vec[gi] = id_valid_i && live && !wb_hit_vec[rs];

        // Walk ports from highest to lowest so the lowest matching port wins.
        always_comb begin
            sel = '0;
            for (int k = NUM_WB - 1; k >= 0; k--) begin
                if (live && wb_valid_i[k] && (wb_addr_i[5*k +: 5] == rs)) begin
                    sel    = '0;
                    sel[k] = 1'b1;
                end
            end
        end

        assign fwd_wb_sel_o[gi*NUM_WB +: NUM_WB] = sel;
    end

    // ------------------------------------------------------------------
    // Destination hazards, stall and issue
    // ------------------------------------------------------------------
    assign rd_nz = (id_rd_addr_i != 5'd0);

    // WAW and structural checks do see cancels: a killed op frees its slot.
    assign waw = id_valid_i && id_rd_we_i && rd_nz &&
                 pending_reg[id_rd_addr_i] && !clear_vec[id_rd_addr_i];

    assign structural = id_valid_i && id_long_i && id_rd_we_i && rd_nz &&
                        (outstanding_reg == OUT_W'(MAX_OUTSTANDING)) &&
                        (clear_eff == 32'd0);

    assign stall = ((|raw_vec) || waw || structural) && !flush_id_i;

    assign issue = id_valid_i && id_long_i && id_rd_we_i && rd_nz &&
                   !stall && !flush_id_i;

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        cleared_cnt = 6'd0;
        for (int r = 0; r < 32; r++) begin
            cleared_cnt = cleared_cnt + 6'(clear_eff[r]);
        end
    end

    assign set_vec = issue ? (32'd1 << id_rd_addr_i) : 32'd0;

    // Set wins over clear on the same address; x0 is never tracked.
    assign pending_next = ((pending_reg & ~clear_vec) | set_vec) & ~32'd1;

    // Re-issuing a register that retires this cycle leaves the count unchanged.
    assign outstanding_sum  = 6'(outstanding_reg) + 6'(issue) - cleared_cnt;
    assign outstanding_next = OUT_W'(outstanding_sum);

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (stall_clr_i) begin
            stall_cnt_next = '0;
        end else if (stall && !(&stall_cnt_reg)) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pending_reg     <= 32'd0;
            outstanding_reg <= '0;
            stall_cnt_reg   <= '0;
        end else begin
            pending_reg     <= pending_next;
            outstanding_reg <= outstanding_next;
            stall_cnt_reg   <= stall_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign stall_id_o    = stall;
    assign pending_o     = pending_reg;
    assign outstanding_o = outstanding_reg;
    assign stall_cnt_o   = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed bench for hazard_scoreboard with default parameters. Expected
// values are queued when a step is driven and popped when the corresponding
// DUT output is sampled (2 time units after the rising edge, or 1 unit after
// a mid-cycle input change).
// ----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int NUM_RS = 2;
    localparam int NUM_WB = 2;
    localparam int OUT_W  = 3;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     id_valid;
    logic [NUM_RS*5-1:0]      id_rs_addr;
    logic [NUM_RS-1:0]        id_rs_used;
    logic [4:0]               id_rd_addr;
    logic                     id_rd_we;
    logic                     id_long;
    logic                     flush_id;
    logic                     cancel_valid;
    logic [4:0]               cancel_addr;
    logic [NUM_WB-1:0]        wb_valid;
    logic [NUM_WB*5-1:0]      wb_addr;
    logic                     stall_clr;
    logic                     stall_id;
    logic [NUM_RS*NUM_WB-1:0] fwd_wb_sel;
    logic [31:0]              pending;
    logic [OUT_W-1:0]         outstanding;
    logic [15:0]              stall_cnt;

    int chk_count = 0;
    int err_count = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .id_valid_i     (id_valid),
        .id_rs_addr_i   (id_rs_addr),
        .id_rs_used_i   (id_rs_used),
        .id_rd_addr_i   (id_rd_addr),
        .id_rd_we_i     (id_rd_we),
        .id_long_i      (id_long),
        .flush_id_i     (flush_id),
        .cancel_valid_i (cancel_valid),
        .cancel_addr_i  (cancel_addr),
        .wb_valid_i     (wb_valid),
        .wb_addr_i      (wb_addr),
        .stall_clr_i    (stall_clr),
        .stall_id_o     (stall_id),
        .fwd_wb_sel_o   (fwd_wb_sel),
        .pending_o      (pending),
        .outstanding_o  (outstanding),
        .stall_cnt_o    (stall_cnt)
    );

    task automatic expect_val(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic observe(input string tag, input logic [31:0] obs);
        exp_t e;
        chk_count++;
        if (sb_q.size() == 0) begin
            err_count++;
            $error("FAIL %s: scoreboard empty, observed=%0h", tag, obs);
        end else begin
            e = sb_q.pop_front();
            assert (e.tag == tag && obs === e.exp)
                $display("check %-14s observed=%0h expected=%0h ok", tag, obs, e.exp);
            else begin
                err_count++;
                $error("FAIL %s: observed=%0h expected=%0h (queued %s)", tag, obs, e.exp, e.tag);
            end
        end
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                            input logic [1:0] used, input logic [4:0] rd,
                            input logic we, input logic lng);
        id_valid   = v;
        id_rs_addr = {rs1, rs0};
        id_rs_used = used;
        id_rd_addr = rd;
        id_rd_we   = we;
        id_long    = lng;
    endtask

    // Two ports retiring the same register is illegal stimulus; flag it.
    task automatic set_wb(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1);
        wb_valid = v;
        wb_addr  = {a1, a0};
        if (v == 2'b11 && a0 == a1) begin
            err_count++;
            $error("FAIL wb_legal: both ports retire x%0d", a0);
        end
    endtask

    task automatic idle();
        drive_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        set_wb(2'b00, 5'd0, 5'd0);
        flush_id     = 1'b0;
        cancel_valid = 1'b0;
        cancel_addr  = 5'd0;
        stall_clr    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #2;
        drive_id(1'b1, 5'd5, 5'd5, 2'b11, 5'd0, 1'b0, 1'b0);
        expect_val("rst_pending", 32'h0);
        expect_val("rst_outst", 32'd0);
        expect_val("rst_cnt", 32'd0);
        expect_val("rst_stall", 32'd0);
        expect_val("rst_fwd", 32'd0);
        settle();
        observe("rst_pending", pending);
        observe("rst_outst", 32'(outstanding));
        observe("rst_cnt", 32'(stall_cnt));
        observe("rst_stall", 32'(stall_id));
        observe("rst_fwd", 32'(fwd_wb_sel));
        rst_n = 1'b1;

        // ---------------- RAW on load x5, resolved by wb port 0 ----------------
        drive_id(1'b1, 5'd1, 5'd2, 2'b00, 5'd5, 1'b1, 1'b1);
        expect_val("ld5_issue", 32'd0);
        settle();
        observe("ld5_issue", 32'(stall_id));
        tick();
        drive_id(1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 1'b0);
        expect_val("ld5_pending", 32'h20);
        expect_val("ld5_outst", 32'd1);
        expect_val("raw5_stall", 32'd1);
        expect_val("raw5_fwd", 32'd0);
        settle();
        observe("ld5_pending", pending);
        observe("ld5_outst", 32'(outstanding));
        observe("raw5_stall", 32'(stall_id));
        observe("raw5_fwd", 32'(fwd_wb_sel));
        tick();
        expect_val("raw5_stall2", 32'd1);
        observe("raw5_stall2", 32'(stall_id));
        tick();
        set_wb(2'b01, 5'd5, 5'd0);
        expect_val("wb5_stall", 32'd0);
        expect_val("wb5_fwd", 32'b0001);
        settle();
        observe("wb5_stall", 32'(stall_id));
        observe("wb5_fwd", 32'(fwd_wb_sel));
        tick();
        idle();
        expect_val("wb5_pending", 32'h0);
        expect_val("wb5_outst", 32'd0);
        expect_val("wb5_cnt", 32'd2);
        settle();
        observe("wb5_pending", pending);
        observe("wb5_outst", 32'(outstanding));
        observe("wb5_cnt", 32'(stall_cnt));

        // ---------------- WAW on x7, released by wb port 1 ----------------
        drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 5'd0, 5'd7, 2'b10, 5'd7, 1'b1, 1'b0);
        expect_val("waw7_pending", 32'h80);
        expect_val("waw7_stall", 32'd1);
        settle();
        observe("waw7_pending", pending);
        observe("waw7_stall", 32'(stall_id));
        tick();
        set_wb(2'b10, 5'd0, 5'd7);
        expect_val("wb7_stall", 32'd0);
        expect_val("wb7_fwd", 32'b1000);
        settle();
        observe("wb7_stall", 32'(stall_id));
        observe("wb7_fwd", 32'(fwd_wb_sel));
        tick();
        idle();
        expect_val("wb7_pending", 32'h0);
        expect_val("wb7_cnt", 32'd3);
        settle();
        observe("wb7_pending", pending);
        observe("wb7_cnt", 32'(stall_cnt));

        // ---------------- structural: fill x1..x4 ----------------
        for (int r = 1; r <= 4; r++) begin
            drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'(r), 1'b1, 1'b1);
            tick();
        end
        drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b1);
        expect_val("full_pending", 32'h1E);
        expect_val("full_outst", 32'd4);
        expect_val("struct_stall", 32'd1);
        settle();
        observe("full_pending", pending);
        observe("full_outst", 32'(outstanding));
        observe("struct_stall", 32'(stall_id));
        tick();
        set_wb(2'b01, 5'd2, 5'd0);
        expect_val("held_outst", 32'd4);
        expect_val("struct_rel", 32'd0);
        settle();
        observe("held_outst", 32'(outstanding));
        observe("struct_rel", 32'(stall_id));
        tick();
        idle();
        expect_val("swap_pending", 32'h5A);
        expect_val("swap_outst", 32'd4);
        settle();
        observe("swap_pending", pending);
        observe("swap_outst", 32'(outstanding));

        // ---------------- wb x9 and reissue x9 in the same cycle ----------------
        set_wb(2'b11, 5'd1, 5'd3);
        tick();
        idle();
        expect_val("drain_pending", 32'h50);
        expect_val("drain_outst", 32'd2);
        settle();
        observe("drain_pending", pending);
        observe("drain_outst", 32'(outstanding));
        drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1);
        tick();
        set_wb(2'b01, 5'd9, 5'd0);
        expect_val("x9_pending", 32'h250);
        expect_val("reiss9_stall", 32'd0);
        settle();
        observe("x9_pending", pending);
        observe("reiss9_stall", 32'(stall_id));
        tick();
        idle();
        expect_val("reiss9_pend", 32'h250);
        expect_val("reiss9_outst", 32'd3);
        settle();
        observe("reiss9_pend", pending);
        observe("reiss9_outst", 32'(outstanding));

        // ---------------- cancel x3 with flush ----------------
        drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 5'd3, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        cancel_valid = 1'b1;
        cancel_addr  = 5'd3;
        expect_val("x3_outst", 32'd4);
        expect_val("cancel_raw", 32'd1);
        expect_val("cancel_fwd", 32'd0);
        settle();
        observe("x3_outst", 32'(outstanding));
        observe("cancel_raw", 32'(stall_id));
        observe("cancel_fwd", 32'(fwd_wb_sel));
        flush_id = 1'b1;
        expect_val("flush_stall", 32'd0);
        settle();
        observe("flush_stall", 32'(stall_id));
        tick();
        idle();
        expect_val("cancel_pend", 32'h250);
        expect_val("cancel_outst", 32'd3);
        settle();
        observe("cancel_pend", pending);
        observe("cancel_outst", 32'(outstanding));

        // ---------------- x0 never stalls, bypasses or sets pending ----------------
        drive_id(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b1, 1'b1);
        set_wb(2'b01, 5'd0, 5'd0);
        expect_val("x0_stall", 32'd0);
        expect_val("x0_fwd", 32'd0);
        settle();
        observe("x0_stall", 32'(stall_id));
        observe("x0_fwd", 32'(fwd_wb_sel));
        tick();
        idle();
        expect_val("x0_pending", 32'h250);
        settle();
        observe("x0_pending", pending);

        // ---------------- clear of a non-pending register has no effect ----------------
        cancel_valid = 1'b1;
        cancel_addr  = 5'd20;
        set_wb(2'b10, 5'd0, 5'd4);
        tick();
        idle();
        expect_val("nop_clr_pend", 32'h240);
        expect_val("nop_clr_outst", 32'd2);
        settle();
        observe("nop_clr_pend", pending);
        observe("nop_clr_outst", 32'(outstanding));

        // ---------------- WAW sees a cancel of its rd ----------------
        drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b0);
        cancel_valid = 1'b1;
        cancel_addr  = 5'd6;
        expect_val("waw_cancel", 32'd0);
        settle();
        observe("waw_cancel", 32'(stall_id));
        tick();
        idle();
        expect_val("waw_cnl_pend", 32'h200);
        expect_val("waw_cnl_outst", 32'd1);
        expect_val("pre_sat_cnt", 32'd4);
        settle();
        observe("waw_cnl_pend", pending);
        observe("waw_cnl_outst", 32'(outstanding));
        observe("pre_sat_cnt", 32'(stall_cnt));

        // ---------------- stall counter priority and saturation ----------------
        drive_id(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        stall_clr = 1'b1;
        expect_val("sat_stall", 32'd1);
        settle();
        observe("sat_stall", 32'(stall_id));
        tick();
        stall_clr = 1'b0;
        expect_val("clr_prio", 32'd0);
        settle();
        observe("clr_prio", 32'(stall_cnt));
        expect_val("saturated", 32'hFFFF);
        repeat (70000) @(posedge clk);
        #2;
        observe("saturated", 32'(stall_cnt));
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        expect_val("sat_clr", 32'd0);
        settle();
        observe("sat_clr", 32'(stall_cnt));
        tick();
        expect_val("post_clr_inc", 32'd1);
        settle();
        observe("post_clr_inc", 32'(stall_cnt));

        // ---------------- asynchronous reset mid-cycle ----------------
        rst_n = 1'b0;
        expect_val("arst_pending", 32'h0);
        expect_val("arst_outst", 32'd0);
        expect_val("arst_cnt", 32'd0);
        settle();
        observe("arst_pending", pending);
        observe("arst_outst", 32'(outstanding));
        observe("arst_cnt", 32'(stall_cnt));

        $display("Simulation finished: %0d checks, %0d errors", chk_count, err_count);
        $finish;
    end

endmodule
